// File: rtl/ov7670_capture_scaler.sv
// rtl/ov7670_capture_scaler.sv - OV7670 byte stream to frame-buffer writes
// Decimates, converts RGB565/grayscale and checks frame geometry in the pclk domain.
module ov7670_capture_scaler #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DECIM      = 1,
  parameter int OUT_W      = IMG_WIDTH / DECIM,
  parameter int OUT_H      = IMG_HEIGHT / DECIM,
  parameter int ADDR_WIDTH = $clog2(OUT_W * OUT_H)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  href,
  input  logic                  vsync,
  input  logic [7:0]            data,
  input  logic                  mode_gray,
  input  logic                  cont,
  input  logic                  arm,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [15:0]           wData,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int XW    = $clog2(IMG_WIDTH + 2) + 1;
  localparam int YW    = $clog2(IMG_HEIGHT + 2) + 1;
  localparam int LOG_D = $clog2(DECIM);
  localparam logic [XW-1:0] W_L = XW'(IMG_WIDTH);
  localparam logic [YW-1:0] H_L = YW'(IMG_HEIGHT);
  localparam logic [XW-1:0] X_M = XW'(DECIM - 1);
  localparam logic [YW-1:0] Y_M = YW'(DECIM - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(OUT_W);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  state_t                state, state_n;
  logic                  href_d, href_q, vsync_d, vsync_q;
  logic [7:0]            data_d, hi_byte;
  logic                  phase;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] row_base;
  logic                  line_err, mode_q, cont_q;

  logic                  frame_start, frame_end, line_end, keep;
  logic [15:0]           pix, pix_out, ysum;
  logic [7:0]            r8, g8, b8;

  assign frame_start = vsync_q & ~vsync_d;
  assign frame_end   = ~vsync_q & vsync_d;
  assign line_end    = href_q & ~href_d;
  assign keep        = (x < W_L) && (y < H_L) && ((x & X_M) == '0) && ((y & Y_M) == '0);
  assign busy        = (state != IDLE);

  // Pixel is assembled from the stored phase-0 byte and the current phase-1 byte.
  always_comb begin
    pix  = {hi_byte, data_d};
    r8   = {pix[15:11], pix[15:13]};
    g8   = {pix[10:5], pix[10:9]};
    b8   = {pix[4:0], pix[4:2]};
    ysum = 16'd77 * {8'h00, r8} + 16'd150 * {8'h00, g8} + 16'd29 * {8'h00, b8};
    pix_out = mode_q ? {8'h00, ysum[15:8]} : pix;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cont || arm) state_n = WAIT_VS;
      WAIT_VS: if (frame_start) state_n = CAPTURE;
      CAPTURE: if (frame_end) state_n = cont_q ? WAIT_VS : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      href_d     <= 1'b0;
      href_q     <= 1'b0;
      vsync_d    <= 1'b0;
      vsync_q    <= 1'b0;
      data_d     <= '0;
      hi_byte    <= '0;
      phase      <= 1'b0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      line_err   <= 1'b0;
      mode_q     <= 1'b0;
      cont_q     <= 1'b0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      href_d     <= href;
      href_q     <= href_d;
      vsync_d    <= vsync;
      vsync_q    <= vsync_d;
      data_d     <= data;
      we         <= 1'b0;
      frame_done <= 1'b0;
      phase      <= href_d ? ~phase : 1'b0;
      if (href_d && !phase) hi_byte <= data_d;

      if (state == WAIT_VS && frame_start) begin
        mode_q    <= mode_gray;
        cont_q    <= cont;
        x         <= '0;
        y         <= '0;
        row_base  <= '0;
        line_err  <= 1'b0;
        frame_err <= 1'b0;
        phase     <= 1'b0;
      end else if (state == CAPTURE) begin
        // Frame end wins over an in-flight pixel; an open line counts as an error.
        if (frame_end) begin
          frame_done <= 1'b1;
          frame_err  <= line_err | (y != H_L) | href_d;
        end else begin
          if (href_d && phase) begin
            if (keep) begin
              we    <= 1'b1;
              wAddr <= row_base + ADDR_WIDTH'(x >> LOG_D);
              wData <= pix_out;
            end
            if (x != '1) x <= x + 1'b1;
          end
          if (line_end) begin
            line_err <= line_err | (x != W_L);
            x        <= '0;
            if (y != '1) y <= y + 1'b1;
            if ((y & Y_M) == '0) row_base <= row_base + ROW_STEP;
          end
        end
      end
    end
  end

endmodule
